mips_run_controller: RTL and testbench
======================================

// Module: mips_run_controller
// PURPOSE
//  Parametrised run/step controller for the debug path. Generates the MIPS core clock-enable
//  (i_ctl_clk_wiz of TOP_MIPS) from commands issued by the debug unit. Supports continuous run,
//  single step and N-step modes, an optional PC breakpoint and halt detection.
//  Keeps a saturating count of enabled cycles and reports why execution stopped.
// PARAMETERS
//  BITS_SIZE   32  width of PC and breakpoint address
//  CNT_BITS    32  width of enabled-cycle counter
//  STEP_BITS   16  width of N-step count
// PORTS
//  i_clk          in   1          system clock (wire_clk_wz domain)
//  i_reset        in   1          async reset, active-high
//  i_cmd_valid    in   1          command strobe, 1 cycle
//  i_cmd          in   2          0=STOP 1=RUN 2=STEP 3=STEP_N
//  i_step_count   in   STEP_BITS  N for STEP_N; sampled with i_cmd_valid
//  i_cnt_clear    in   1          synchronous clear of o_cycle_count
//  i_halt         in   1          core halted (o_mips_halt)
//  i_pc           in   BITS_SIZE  current core PC
//  i_bp_enable    in   1          breakpoint armed
//  i_bp_addr      in   BITS_SIZE  breakpoint PC
//  o_clk_en       out  1          core clock-enable, combinational from state and stop conditions
//  o_busy         out  1          state != IDLE
//  o_done         out  1          1-cycle pulse on entering DONE
//  o_stop_cause   out  3          0=NONE 1=HALT 2=BREAK 3=USER 4=STEPS
//  o_cycle_count  out  CNT_BITS   enabled cycles since reset/clear, saturating
//  o_state        out  2          IDLE=0 RUN=1 STEP=2 DONE=3
// BEHAVIOUR
//  Reset: state=IDLE, o_clk_en=0, o_done=0, o_stop_cause=0, o_cycle_count=0, remaining=0, first=0.
//  IDLE: o_clk_en=0.
//   - i_cmd_valid && RUN    -> RUN, first<=1.
//   - STEP                  -> STEP, remaining<=1.
//   - STEP_N                -> STEP, remaining<=i_step_count; a count of 0 is treated as 1.
//   - STOP in IDLE is ignored. o_stop_cause is cleared to 0 on acceptance of any RUN/STEP/STEP_N.
//  RUN: bp_hit = i_bp_enable && i_pc==i_bp_addr && !first. first<=0 after each RUN cycle.
//   - Stop priority: i_halt(HALT) > bp_hit(BREAK) > STOP command(USER).
//   - If any stop condition holds: o_clk_en=0 this cycle, next state=DONE, cause latched.
//   - Otherwise o_clk_en=1. The breakpoint instruction is not clocked.
//   - Resuming RUN from a breakpointed PC executes it, because first masks the match.
//  STEP: o_clk_en = !i_halt && !(i_cmd_valid && i_cmd==STOP).
//   - i_halt -> DONE cause HALT; STOP -> DONE cause USER (HALT wins if both).
//   - Each enabled cycle decrements remaining. Enabled with remaining==1 -> DONE cause STEPS.
//   - So exactly N enables are issued. The breakpoint is ignored in STEP.
//  DONE: o_clk_en=0, o_done=1 for this single cycle, then IDLE. Cause holds until the next accepted run command.
//  Commands other than STOP while RUN/STEP/DONE are ignored (no queueing).
//  o_cycle_count:
//   - Increments on every cycle with o_clk_en=1 and saturates at 2^CNT_BITS-1.
//   - i_cnt_clear wins over increment (count=0 next cycle).
//  Async reset mid-RUN/STEP: o_clk_en drops immediately (combinational from reset state).
// TESTING
//  T1 STEP_N cnt=5 from IDLE, no halt -> o_clk_en high exactly 5 cycles; o_done pulse; cause=4; count=5.
//  T2 RUN, i_halt raised on 10th enabled cycle -> clk_en low that cycle; cause=1; count=9.
//  T3 bp_addr=0x10, PC=0x0,0x4..: RUN -> stops with PC=0x10, cause=2; RUN again -> PC passes 0x10; next stop not at 0x10.
//  T4 RUN then STOP strobe at cycle 7 -> clk_en low at cycle 7, cause=3; RUN/STEP strobes during RUN ignored.
//  T5 STEP_N cnt=0 -> one enable, cause=4; STEP_N cnt=3 with halt on 2nd -> 1 enable, cause=1.
//  T6 CNT_BITS=4, RUN 20 cycles -> count saturates at 15; i_cnt_clear -> 0; reset mid-STEP -> clk_en=0, state=IDLE.

Source files
------------

// File: rtl/mips_run_controller.sv
// mips_run_controller: run/step controller that gates the MIPS core clock
// for the debug unit.
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_cmd_valid, i_cmd        1-cycle command strobe; 0=STOP 1=RUN 2=STEP 3=STEP_N
//   i_step_count              N for STEP_N (0 runs one step)
//   i_cnt_clear               synchronous clear of the enabled-cycle counter
//   i_halt                    core halted
//   i_pc, i_bp_enable,
//   i_bp_addr                 core PC and breakpoint
//   o_clk_en                  core clock-enable
//   o_busy, o_done, o_state   controller status; o_done pulses in DONE
//   o_stop_cause              0=NONE 1=HALT 2=BREAK 3=USER 4=STEPS
//   o_cycle_count             saturating count of enabled cycles
module mips_run_controller #(
    parameter int BITS_SIZE = 32,
    parameter int CNT_BITS  = 32,
    parameter int STEP_BITS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    input  logic [STEP_BITS-1:0] i_step_count,
    input  logic                 i_cnt_clear,
    input  logic                 i_halt,
    input  logic [BITS_SIZE-1:0] i_pc,
    input  logic                 i_bp_enable,
    input  logic [BITS_SIZE-1:0] i_bp_addr,
    output logic                 o_clk_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2:0]           o_stop_cause,
    output logic [CNT_BITS-1:0]  o_cycle_count,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] CMD_STOP   = 2'd0;
    localparam logic [1:0] CMD_RUN    = 2'd1;
    localparam logic [1:0] CMD_STEP   = 2'd2;
    localparam logic [1:0] CMD_STEP_N = 2'd3;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_HALT  = 3'd1;
    localparam logic [2:0] CAUSE_BREAK = 3'd2;
    localparam logic [2:0] CAUSE_USER  = 3'd3;
    localparam logic [2:0] CAUSE_STEPS = 3'd4;

    localparam logic [STEP_BITS-1:0] STEP_ONE = STEP_BITS'(1);
    localparam logic [CNT_BITS-1:0]  CNT_ONE  = CNT_BITS'(1);

    state_t               state_q, state_d;
    logic                 first_q, first_d;
    logic [STEP_BITS-1:0] remaining_q, remaining_d;
    logic [2:0]           cause_q, cause_d;
    logic [CNT_BITS-1:0]  count_q, count_d;

    logic stop_cmd;
    logic bp_hit;
    logic clk_en;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            remaining_q <= '0;
            cause_q     <= CAUSE_NONE;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            remaining_q <= remaining_d;
            cause_q     <= cause_d;
            count_q     <= count_d;
        end
    end

    assign stop_cmd = i_cmd_valid && (i_cmd == CMD_STOP);
    // The first RUN cycle ignores the breakpoint so that resuming from a
    // breakpointed PC executes that instruction.
    assign bp_hit   = i_bp_enable && (i_pc == i_bp_addr) && !first_q;

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        remaining_d = remaining_q;
        cause_d     = cause_q;
        clk_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    unique case (i_cmd)
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            first_d = 1'b1;
                            cause_d = CAUSE_NONE;
                        end
                        CMD_STEP: begin
                            state_d     = ST_STEP;
                            remaining_d = STEP_ONE;
                            cause_d     = CAUSE_NONE;
                        end
                        CMD_STEP_N: begin
                            state_d     = ST_STEP;
                            remaining_d = (i_step_count == '0) ?
                                          STEP_ONE : i_step_count;
                            cause_d     = CAUSE_NONE;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_RUN: begin
                first_d = 1'b0;
                if (i_halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (bp_hit) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_BREAK;
                end else if (stop_cmd) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_USER;
                end else begin
                    clk_en = 1'b1;
                end
            end
            ST_STEP: begin
                if (i_halt) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_HALT;
                end else if (stop_cmd) begin
                    state_d = ST_DONE;
                    cause_d = CAUSE_USER;
                end else begin
                    clk_en      = 1'b1;
                    remaining_d = remaining_q - STEP_ONE;
                    // The last enabled step also ends the sequence.
                    if (remaining_q <= STEP_ONE) begin
                        state_d     = ST_DONE;
                        cause_d     = CAUSE_STEPS;
                        remaining_d = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (i_cnt_clear) begin
            count_d = '0;
        end else if (clk_en && (count_q != '1)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    assign o_clk_en      = clk_en;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_stop_cause  = cause_q;
    assign o_cycle_count = count_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller: directed and randomized checks of the run/step
// controller against an arithmetic model of stop cycle, cause and count.
module tb_mips_run_controller;

    localparam int CB   = 4;
    localparam int CMAX = 15;
    localparam int BIG  = 1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [15:0] step_count;
    logic        cnt_clear;
    logic        halt;
    logic [31:0] pc;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic        clk_en;
    logic        busy;
    logic        done;
    logic [2:0]  cause;
    logic [CB-1:0] cnt;
    logic [1:0]  state;

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;

    mips_run_controller #(
        .BITS_SIZE(32),
        .CNT_BITS (CB),
        .STEP_BITS(16)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cmd_valid  (cmd_valid),
        .i_cmd        (cmd),
        .i_step_count (step_count),
        .i_cnt_clear  (cnt_clear),
        .i_halt       (halt),
        .i_pc         (pc),
        .i_bp_enable  (bp_en),
        .i_bp_addr    (bp_addr),
        .o_clk_en     (clk_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_stop_cause (cause),
        .o_cycle_count(cnt),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Reference: which cycle of the operation stops it, and why.
    function automatic void model(input logic [1:0] c, input int n,
                                  input int h, input int s,
                                  input bit bpon, input int bp,
                                  input int pc0, output int en,
                                  output int cs, output int endc);
        int stop;
        int k;
        int nn;
        stop = BIG;
        cs   = 0;
        if (h > 0 && h < stop) begin
            stop = h;
            cs   = 1;
        end
        if (c == 2'd1) begin
            // PC on cycle i is pc0 + 4*(i-1); cycle 1 is masked.
            if (bpon && bp >= pc0 && ((bp - pc0) % 4) == 0) begin
                k = (bp - pc0) / 4 + 1;
                if (k >= 2 && k < stop) begin
                    stop = k;
                    cs   = 2;
                end
            end
            if (s > 0 && s < stop) begin
                stop = s;
                cs   = 3;
            end
            en   = stop - 1;
            endc = stop;
        end else begin
            nn = (c == 2'd2) ? 1 : ((n == 0) ? 1 : n);
            if (s > 0 && s < stop) begin
                stop = s;
                cs   = 3;
            end
            if (stop <= nn) begin
                en   = stop - 1;
                endc = stop;
            end else begin
                en   = nn;
                cs   = 4;
                endc = nn;
            end
        end
    endfunction

    task automatic run_op(input logic [1:0] c, input int n, input int h,
                          input int s, input int nz, input int clr,
                          output int en, output int cs);
        bit ok;
        bit enb;
        ok = 1'b0;
        en = 0;
        cs = 7;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd        = c;
        step_count = n[15:0];
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            halt      = (i == h);
            cnt_clear = (i == clr);
            if (i == s) begin
                cmd_valid = 1'b1;
                cmd       = 2'd0;
            end else if (i == nz) begin
                cmd_valid = 1'b1;
                cmd       = 2'($urandom_range(1, 3));
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            if (i == 1) check("busy_in_op", busy, 1);
            if (done) begin
                ok = 1'b1;
                cs = cause;
                check("done_state", state, 3);
                break;
            end
            enb = clk_en;
            if (enb) en++;
            @(posedge clk); #1;
            if (enb) pc = pc + 32'd4;
        end
        if (!ok) check("op_timeout", 0, 1);
        @(posedge clk); #1;
        halt      = 1'b0;
        cmd_valid = 1'b0;
        cnt_clear = 1'b0;
        @(negedge clk);
        check("idle_after_done", {busy, done, state}, 0);
    endtask

    task automatic clear_cnt();
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        int en;
        int cs;
        int e_en;
        int e_cs;
        int endc;
        int c;
        int n;
        int h;
        int s;
        int nz;
        int clr;
        int bp;
        bit bpon;
        int pc0;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd        = 2'd0;
        step_count = '0;
        cnt_clear  = 1'b0;
        halt       = 1'b0;
        pc         = '0;
        bp_en      = 1'b0;
        bp_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {clk_en, busy, done, cause, state}, 0);
        check("reset_count", cnt, 0);
        rst = 1'b0;

        // STOP in IDLE is ignored
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd       = 2'd0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("stop_in_idle", {busy, state}, 0);

        // T1
        run_op(2'd3, 5, 0, 0, 0, 0, en, cs);
        check("t1_enables", en, 5);
        check("t1_cause", cs, 4);
        check("t1_count", cnt, 5);

        // T2
        clear_cnt();
        run_op(2'd1, 0, 10, 0, 0, 0, en, cs);
        check("t2_enables", en, 9);
        check("t2_cause", cs, 1);
        check("t2_count", cnt, 9);

        // T3
        clear_cnt();
        pc      = 32'h0;
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        run_op(2'd1, 0, 0, 0, 0, 0, en, cs);
        check("t3_bp_cause", cs, 2);
        check("t3_bp_pc", pc, 32'h10);
        check("t3_bp_enables", en, 4);
        run_op(2'd1, 0, 0, 6, 0, 0, en, cs);
        check("t3_resume_cause", cs, 3);
        check("t3_resume_pc", pc, 32'h24);
        check("t3_count", cnt, 9);
        bp_en = 1'b0;

        // T4
        clear_cnt();
        run_op(2'd1, 0, 0, 7, 3, 0, en, cs);
        check("t4_enables", en, 6);
        check("t4_cause", cs, 3);
        check("t4_count", cnt, 6);

        // T5
        clear_cnt();
        run_op(2'd3, 0, 0, 0, 0, 0, en, cs);
        check("t5_zero_enables", en, 1);
        check("t5_zero_cause", cs, 4);
        run_op(2'd3, 3, 2, 0, 0, 0, en, cs);
        check("t5_halt_enables", en, 1);
        check("t5_halt_cause", cs, 1);
        check("t5_count", cnt, 2);

        // T6: saturation, clear, clear-over-increment, reset mid-STEP
        clear_cnt();
        run_op(2'd1, 0, 0, 21, 0, 0, en, cs);
        check("t6_enables", en, 20);
        check("t6_saturate", cnt, 15);
        clear_cnt();
        @(negedge clk);
        check("t6_clear", cnt, 0);
        run_op(2'd1, 0, 0, 9, 0, 4, en, cs);
        check("t6_clear_in_run", cnt, 4);
        run_op(2'd3, 10, 0, 0, 0, 0, en, cs);
        check("t6_cause_holds", cause, 4);
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd        = 2'd3;
        step_count = 16'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_step_enabled", clk_en, 1);
        rst = 1'b1;
        #1;
        check("t6_reset_clk_en", clk_en, 0);
        check("t6_reset_state", state, 0);
        check("t6_reset_count", cnt, 0);
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = 0;

        // Randomized operations against the model
        for (int t = 0; t < 40; t++) begin
            c    = $urandom_range(1, 3);
            n    = $urandom_range(0, 12);
            h    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 20) : 0;
            s    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 25) : 0;
            if (c == 1 && s == 0) s = $urandom_range(1, 25);
            bpon = 1'($urandom_range(0, 1));
            pc0  = int'(pc);
            bp   = pc0 + 4 * $urandom_range(0, 15);
            model(2'(c), n, h, s, bpon, bp, pc0, e_en, e_cs, endc);
            nz   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, endc) : 0;
            if (nz == s) nz = 0;
            clr  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, endc) : 0;
            bp_en   = bpon;
            bp_addr = 32'(bp);
            run_op(2'(c), n, h, s, nz, clr, en, cs);
            if (clr > 0) begin
                model_cnt = sat(e_en - ((clr < e_en) ? clr : e_en));
            end else begin
                model_cnt = sat(model_cnt + e_en);
            end
            check("rnd_enables", en, e_en);
            check("rnd_cause", cs, e_cs);
            check("rnd_count", cnt, model_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
